data_ram_arbiter: RTL and testbench

//  Two-port arbiter and sequencer for the 32x32 byte-writable data RAM (async read, sync write).

---
 rtl/data_ram_arb_pkg.sv | 14 +
 rtl/data_ram_arb_pick.sv | 31 +++
 rtl/data_ram_arbiter.sv | 104 ++++++++++
 tb/tb_data_ram_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_arb_pkg.sv
// Shared encodings for the data RAM arbiter: FSM states, port ids and default widths.
package data_ram_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/data_ram_arb_pick.sv
// Combinational 2-way picker. DATA_RAM_ARB_RR_EN selects round-robin, else port 0 wins ties.
module data_ram_arb_pick
  import data_ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_win,
  output logic any,
  output logic win
);

  assign any = req0 | req1;

`ifdef DATA_RAM_ARB_RR_EN
  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    win = PORT_CPU;
    if (req0 && req1) win = ~last_win;
    else if (req1)    win = PORT_DBG;
  end
`else
  logic unused_last;
  assign unused_last = last_win;

  always_comb begin
    win = PORT_CPU;
    if (!req0 && req1) win = PORT_DBG;
  end
`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter/sequencer for the byte-writable data RAM (async read, sync write).
// Arbitration policy is set by the DATA_RAM_ARB_RR_EN macro in data_ram_arb_pick.
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  localparam int BW = DW / 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0,
  input  logic          we0,
  input  logic [BW-1:0] be0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [BW-1:0] be1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [BW-1:0] ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic [1:0]    state;
  logic          win;
  logic          last_win;
  logic          cmd_we;
  logic [BW-1:0] cmd_be;
  logic          any;
  logic          pick;
  logic          arb_ok;

  data_ram_arb_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_win (last_win),
    .any      (any),
    .win      (pick)
  );

  assign arb_ok = (state == IDLE) || (state == RESP);

  // ram_addr/ram_wdata are the latched command itself, so the RAM sees it for the whole ACCESS cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      win       <= PORT_CPU;
      last_win  <= PORT_DBG;  // priority pointer starts at port 0
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (any) begin
            state    <= ACCESS;
            win      <= pick;
            last_win <= pick;
            if (pick == PORT_CPU) begin
              cmd_we    <= we0;
              cmd_be    <= be0;
              ram_addr  <= addr0;
              ram_wdata <= wdata0;
            end else begin
              cmd_we    <= we1;
              cmd_be    <= be1;
              ram_addr  <= addr1;
              ram_wdata <= wdata1;
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          // Write responses return zero so a stale read value never leaks out.
          if (win == PORT_CPU) rdata0 <= cmd_we ? '0 : ram_rdata;
          else                 rdata1 <= cmd_we ? '0 : ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_wen = (state == ACCESS) ? (cmd_be & {BW{cmd_we}}) : '0;
  assign gnt0    = (state == ACCESS) && (win == PORT_CPU);
  assign gnt1    = (state == ACCESS) && (win == PORT_DBG);
  assign rvalid0 = (state == RESP)   && (win == PORT_CPU);
  assign rvalid1 = (state == RESP)   && (win == PORT_DBG);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural 32x32 byte-writable RAM.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [3:0]  be0 = 0, be1 = 0;
  logic [4:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [3:0]  ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [32];
  logic        mem_clr = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_ram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transaction on a port; returns response data and cycles from req to gnt.
  task automatic xfer(input logic port, input logic we, input logic [3:0] be,
                      input logic [4:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    if (port == 1'b0) begin
      req0 = 1; we0 = we; be0 = be; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1; we1 = we; be1 = be; addr1 = addr; wdata1 = wd;
    end
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(port ? gnt1 : gnt0) && lat < 8);
    chk("gnt_own", {31'b0, port ? gnt1 : gnt0}, 32'd1);
    chk("gnt_other", {31'b0, port ? gnt0 : gnt1}, 32'd0);
    step();
    if (port == 1'b0) req0 = 0; else req1 = 0;
    chk("rvalid_own", {31'b0, port ? rvalid1 : rvalid0}, 32'd1);
    chk("rvalid_other", {31'b0, port ? rvalid0 : rvalid1}, 32'd0);
    rd = port ? rdata1 : rdata0;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          n;
    logic        seq [4];

    step();
    step();
    mem_clr = 1'b0;
    // Reset state
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
    chk("rst_wen", {28'b0, ram_wen}, 32'd0);
    chk("rst_addr", {27'b0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    resetn = 1'b1;
    step();

    // 1. port 0 write then back-to-back read of the same word
    xfer(1'b0, 1'b1, 4'hF, 5'd3, 32'h12345678, rd, lat);
    chk("t1_lat", lat, 32'd1);
    chk("t1_wr_rdata", rd, 32'd0);
    xfer(1'b0, 1'b0, 4'h0, 5'd3, 32'h0, rd, lat);
    chk("t1_rd_rdata", rd, 32'h12345678);
    chk("t1_mem3", mem[3], 32'h12345678);

    // 2. port 1 partial byte write over a zeroed word
    xfer(1'b1, 1'b1, 4'b0010, 5'd5, 32'hAABBCCDD, rd, lat);
    xfer(1'b1, 1'b0, 4'h0, 5'd5, 32'h0, rd, lat);
    chk("t2_rdata1", rd, 32'h0000CC00);
    step(); step();

    // 3. both ports held for four accesses
    req0 = 1; we0 = 0; addr0 = 5'd3;
    req1 = 1; we1 = 0; addr1 = 5'd5;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t3_gnt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
      chk("t3_rv_excl", {31'b0, rvalid0 & rvalid1}, 32'd0);
      if ((gnt0 || gnt1) && n < 4) begin
        seq[n] = gnt1;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    chk("t3_count", n, 32'd4);
`ifdef DATA_RAM_ARB_RR_EN
    chk("t3_g0", {31'b0, seq[0]}, 32'd0);
    chk("t3_g1", {31'b0, seq[1]}, 32'd1);
    chk("t3_g2", {31'b0, seq[2]}, 32'd0);
    chk("t3_g3", {31'b0, seq[3]}, 32'd1);
`else
    for (int i = 0; i < 4; i++) chk("t3_fixed", {31'b0, seq[i]}, 32'd0);
`endif
    step(); step(); step();

    // 4. continuous port 0 writes: ACCESS/RESP alternate, wen only in ACCESS
    req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 5'd10; wdata0 = 32'hCAFEF00D;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("t4_gnt", {31'b0, gnt0}, (c % 2) ? 32'd1 : 32'd0);
      chk("t4_rvalid", {31'b0, rvalid0}, (c % 2) ? 32'd0 : 32'd1);
      chk("t4_wen", {28'b0, ram_wen}, (c % 2) ? 32'hF : 32'h0);
    end
    req0 = 0;
    step(); step();
    chk("t4_mem10", mem[10], 32'hCAFEF00D);

    // 5. reset asserted during the ACCESS cycle of a write
    xfer(1'b0, 1'b1, 4'hF, 5'd7, 32'h11112222, rd, lat);
    step(); step();
    req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 5'd7; wdata0 = 32'hDEADBEEF;
    step();
    chk("t5_pre_gnt", {31'b0, gnt0}, 32'd1);
    chk("t5_pre_wen", {28'b0, ram_wen}, 32'hF);
    #2 resetn = 1'b0;
    #1;
    chk("t5_wen_now", {28'b0, ram_wen}, 32'd0);
    chk("t5_gnt_now", {31'b0, gnt0}, 32'd0);
    req0 = 0;
    step();
    resetn = 1'b1;
    chk("t5_mem7", mem[7], 32'h11112222);
    chk("t5_rdata0", rdata0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_idle", {28'b0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
    end
    xfer(1'b0, 1'b0, 4'h0, 5'd7, 32'h0, rd, lat);
    chk("t5_lat", lat, 32'd1);
    chk("t5_rd7", rd, 32'h11112222);

    // 6. write with no byte enables
    xfer(1'b0, 1'b1, 4'hF, 5'd9, 32'h5A5A5A5A, rd, lat);
    xfer(1'b0, 1'b0, 4'h0, 5'd9, 32'h0, rd, lat);
    chk("t6_pre", rd, 32'h5A5A5A5A);
    xfer(1'b0, 1'b1, 4'h0, 5'd9, 32'hFFFFFFFF, rd, lat);
    chk("t6_wr_rdata", rd, 32'd0);
    chk("t6_mem9", mem[9], 32'h5A5A5A5A);
    xfer(1'b0, 1'b0, 4'h0, 5'd9, 32'h0, rd, lat);
    chk("t6_rd9", rd, 32'h5A5A5A5A);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
